// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch stage and the decode-side control unit.
package riscv_pkg;

    localparam logic [6:0] OP_LW        = 7'b0000011;
    localparam logic [6:0] OP_SW        = 7'b0100011;
    localparam logic [6:0] OP_RTYPE     = 7'b0110011;
    localparam logic [6:0] OP_BEQ       = 7'b1100011;
    localparam logic [6:0] OP_ITYPE_ALU = 7'b0010011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_skid.sv
// One-entry instruction+PC buffer that catches a response while decode is stalled.
module fetch_skid
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            pop,
    input  logic            flush,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc
);

    // Flush wins so a redirect never leaves a stale entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to imem,
// and presents the fetched word plus its decode fields to the control unit.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7b5
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            kill;
    logic            out_valid;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;

    logic            accept;
    logic            consume;
    logic            rsp_live;
    logic            skid_load;
    logic            skid_pop;
    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    // Request is masked by rst_n so nothing is offered to memory during reset.
    assign imem_req_valid = rst_n && (state == S_REQ);
    assign imem_addr      = pc & ALIGN_MASK;
    assign accept         = imem_req_valid && imem_req_ready;
    assign consume        = out_valid && !stall;
    assign rsp_live       = (state == S_WAIT) && imem_rsp_valid && !kill;

    assign skid_load = !redirect_valid && rsp_live && out_valid && stall;
    assign skid_pop  = !redirect_valid && (state == S_HOLD) && consume && skid_valid;

    fetch_skid #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .pop        (skid_pop),
        .flush      (redirect_valid),
        .load_instr (imem_rdata),
        .load_pc    (inflight_pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // Redirect overrides everything; a request already accepted is marked for kill
    // unless its response lands in the same cycle and can simply be dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            kill        <= 1'b0;
            out_valid   <= 1'b0;
            out_instr   <= NOP_INSTR;
            out_pc      <= '0;
        end else if (redirect_valid) begin
            pc        <= redirect_target & ALIGN_MASK;
            out_valid <= 1'b0;
            case (state)
                S_REQ: begin
                    if (accept) begin
                        kill  <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        kill  <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        kill <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            if (consume) out_valid <= 1'b0;
            case (state)
                S_REQ: begin
                    if (accept) begin
                        inflight_pc <= pc;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid && kill) begin
                        kill  <= 1'b0;
                        state <= S_REQ;
                    end else if (rsp_live && (!out_valid || consume)) begin
                        out_valid <= 1'b1;
                        out_instr <= imem_rdata;
                        out_pc    <= inflight_pc;
                        pc        <= inflight_pc + XLEN'(4);
                        state     <= S_REQ;
                    end else if (rsp_live) begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (skid_pop) begin
                        out_valid <= 1'b1;
                        out_instr <= skid_instr;
                        out_pc    <= skid_pc;
                        pc        <= skid_pc + XLEN'(4);
                        state     <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Decode sees a NOP whenever nothing live is presented.
    assign instr_valid    = out_valid;
    assign instr          = out_valid ? out_instr : NOP_INSTR;
    assign instr_pc       = out_pc;
    assign instr_pc_plus4 = out_pc + XLEN'(4);
    assign opcode         = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7b5       = instr[30];

endmodule
